// File: rtl/logic_op_pipe_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface : logic_op_pipe_if                                     |
// | Purpose   : input/output valid-ready streams of logic_op_pipe.   |
// |             out_pop exists only with LOGIC_OP_PIPE_POPCOUNT_EN.  |
// | Revision  : 1.0 - initial release                                |
// +------------------------------------------------------------------+
interface logic_op_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_c;
  logic             out_last;
`ifdef LOGIC_OP_PIPE_POPCOUNT_EN
  localparam int POP_W = $clog2(WIDTH + 1);
  logic [POP_W-1:0] out_pop;

  modport master (
    output in_valid, in_a, in_b, in_op, in_last, out_ready,
    input  in_ready, out_valid, out_c, out_last, out_pop
  );
  modport slave (
    input  in_valid, in_a, in_b, in_op, in_last, out_ready,
    output in_ready, out_valid, out_c, out_last, out_pop
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_op, in_last, out_ready,
    input  in_ready, out_valid, out_c, out_last
  );
  modport slave (
    input  in_valid, in_a, in_b, in_op, in_last, out_ready,
    output in_ready, out_valid, out_c, out_last
  );
`endif
endinterface
`default_nettype wire

// File: rtl/logic_op_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module    : logic_op_pipe                                        |
// | Purpose   : registered bitwise AND/OR/XOR/accumulating-AND with  |
// |             valid/ready streams and a 2-entry output FIFO.       |
// |             Define LOGIC_OP_PIPE_POPCOUNT_EN to add out_pop.     |
// | Revision  : 1.0 - initial release                                |
// +------------------------------------------------------------------+
module logic_op_pipe #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  logic_op_pipe_if.slave  bus
);

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;

`ifdef LOGIC_OP_PIPE_POPCOUNT_EN
  localparam int POP_W   = $clog2(WIDTH + 1);
  localparam int ENTRY_W = WIDTH + 1 + POP_W;

  function automatic logic [POP_W-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [POP_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) sum = sum + POP_W'(v[i]);
    return sum;
  endfunction
`else
  localparam int ENTRY_W = WIDTH + 1;
`endif

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_next;
  logic [1:0]         count;
  logic [ENTRY_W-1:0] mem [2];
  logic [ENTRY_W-1:0] entry;
  logic [WIDTH-1:0]   res;
  logic               is_acc;
  logic               accept;
  logic               push;
  logic               pop;

  // in_ready looks only at occupancy, so downstream ready never feeds back combinationally
  assign bus.in_ready  = (count < 2'd2) && !rst;
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_c     = mem[0][WIDTH-1:0];
  assign bus.out_last  = mem[0][WIDTH];
`ifdef LOGIC_OP_PIPE_POPCOUNT_EN
  assign bus.out_pop   = mem[0][ENTRY_W-1 -: POP_W];
`endif

  assign is_acc = (bus.in_op == 2'd3);
  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = (count != 2'd0) && bus.out_ready;
  // non-last ACC beats only fold into acc; everything else produces a result
  assign push   = accept && (!is_acc || bus.in_last);

  // Result of the selected operation and the FIFO entry built from it
  always_comb begin
    res = '0;
    case (bus.in_op)
      OP_AND:  res = bus.in_a & bus.in_b;
      OP_OR:   res = bus.in_a | bus.in_b;
      OP_XOR:  res = bus.in_a ^ bus.in_b;
      default: res = acc & bus.in_a & bus.in_b;
    endcase
`ifdef LOGIC_OP_PIPE_POPCOUNT_EN
    entry = {popcnt(res), is_acc | bus.in_last, res};
`else
    entry = {is_acc | bus.in_last, res};
`endif
  end

  // Accumulator / burst FSM next state; pass-through ops leave both untouched
  always_comb begin
    state_next = state;
    acc_next   = acc;
    if (accept && is_acc) begin
      if (bus.in_last) begin
        acc_next   = '1;
        state_next = IDLE;
      end else begin
        acc_next = acc & bus.in_a & bus.in_b;
        if (state == IDLE) state_next = ACCUM;
      end
    end
  end

  // Accumulator / FSM state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '1;
    end else begin
      state <= state_next;
      acc   <= acc_next;
    end
  end

  // Shift-style 2-entry FIFO: slot 0 is always the head seen on the output
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          mem[count[0]] <= entry;
          count         <= count + 2'd1;
        end
        2'b01: begin
          mem[0] <= mem[1];
          count  <= count - 2'd1;
        end
        // push with pop only happens at count 1: new entry replaces the head
        2'b11:   mem[0] <= entry;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/logic_op_pipe.md
# logic_op_pipe

- Parametrised, registered successor to the team's two-input combinational AND gate.
- Applies a selectable bitwise operation (AND, OR, XOR, or multi-beat accumulating AND) to two WIDTH-bit operands.
- Transfers data over valid/ready streams through a 2-entry output FIFO.
- Sits between a stimulus/source stage and any downstream consumer that may apply backpressure.

## Interface

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥1.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  2  operation: 0 AND, 1 OR, 2 XOR, 3 ACC (accumulating AND).
- in_last  input  1  marks the final beat of an ACC burst; passed through for ops 0–2.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result beat.
- out_c  output  WIDTH  result.
- out_last  output  1  last flag associated with the result.
- out_pop  output  $clog2(WIDTH+1)  popcount of out_c; present only with LOGIC_OP_PIPE_POPCOUNT_EN.

## Operation

- A beat is accepted when in_valid && in_ready; a result is consumed when out_valid && out_ready.
- Ops 0–2: result = a&b, a|b or a^b; one result is pushed per accepted beat; out_last = in_last.
- ACC op: uses register acc (WIDTH bits, reset all-ones) and FSM states IDLE and ACCUM.
  - Beat with in_last=0: acc <= acc & a & b; no result is pushed. In IDLE, the FSM moves to ACCUM.
  - Beat with in_last=1: pushes acc & a & b with out_last=1; acc <= all-ones; FSM -> IDLE.
  - A single-beat ACC (IDLE, last=1) yields a&b.
- Ops 0–2 accepted while in ACCUM pass through normally and leave acc and the FSM state unchanged.
- Output FIFO: 2 entries, strict FIFO order, count 0..2.
  - in_ready = (count < 2) && !rst.
  - in_ready depends only on count, never combinationally on out_ready.
- Simultaneous push and pop:
  - count=1: count stays 1; the popped entry is the older one.
  - count=2: cannot occur, because in_ready is low.
- An ACC non-last beat needs no FIFO slot, but in_ready is still governed by count.

## Timing

- Reset values: in_ready=0 while rst is high, 1 in the first cycle after rst deasserts; out_valid=0, out_c=0, out_last=0, out_pop=0; acc=all-ones, FSM=IDLE, count=0.
- Latency: a beat accepted at edge N shows its result at out_valid after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle while out_ready is held high.
- Under backpressure, out_c and out_last stay stable while out_valid && !out_ready.
- Reset mid-burst: the FIFO is flushed, acc returns to all-ones and the FSM returns to IDLE. Partial ACC state is discarded and emits no result.
- Arithmetic: bitwise only; no carries. out_pop is in the range 0..WIDTH and its width is exact.

## Configuration

- LOGIC_OP_PIPE_POPCOUNT_EN defined:
  - out_pop exists.
  - Popcount is computed at push time and stored in the FIFO alongside each result.
  - It is valid in the same cycle as out_c.
- Undefined: out_pop and its FIFO storage are absent; all other behaviour is identical.

## Test plan

- Truth-table sweep, WIDTH=8, out_ready=1: a=8'hF0, b=8'hCC with op 0/1/2 -> out_c=8'hC0/8'hFC/8'h3C, each one cycle after acceptance.
- ACC burst: (FF,FE,last0), (F7,FF,last0), (7F,FF,last1) -> exactly one result, out_c=8'h76, out_last=1; acc reads all-ones afterward.
- Backpressure: out_ready=0, push 3 XOR beats -> in_ready drops after 2 accepts; out_c holds the first result. Raising out_ready drains the results in order and in_ready reasserts.
- Simultaneous push/pop at count=1 over 10 cycles -> count stays 1 and there is no loss or duplication.
- Reset after 2 ACC non-last beats -> out_valid=0, in_ready=0 during reset. A following single ACC beat (AA,0F,last1) yields 8'h0A.
- With LOGIC_OP_PIPE_POPCOUNT_EN: OR of 8'h0F and 8'h30 -> out_c=8'h3F, out_pop=6.
